fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Producer side of the F/D pipeline-register interface in the P7 MIPS CPU with CP0 exceptions.
- Owns the architectural fetch PC and drives the IM address.
- Generates the F-stage bundle the F/D register latches: PC, instr, delay-slot flag, exception code.
- Handles redirects for kernel entry (int_exc_req), eret and branch/jump, plus the null-slot kill.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- PC_KERNEL, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high.
- en  in  1  F-stage enable (0 = stall, hold PC).
- npc_sel  in  1  1 = branch/jump in D taken, use D_npc.
- D_npc  in  32  branch/jump target from D.
- D_is_jump  in  1  D holds branch/jump, so current F instr is its delay slot.
- D_eret  in  1  D holds eret.
- epc  in  32  CP0 EPC, forwarded.
- int_exc_req  in  1  CP0 takes interrupt/exception this cycle.
- im_rdata  in  32  instruction memory read data for im_addr.
- im_addr  out  32  equals F_PC.
- F_PC  out  32  fetch PC.
- F_instr  out  32  fetched instruction, 0 when F_exc_code != 0.
- F_DB  out  1  delay-slot flag.
- F_exc_code  out  5  0 or AdEL (5'd4).
- null_slot  out  1  kill request to the F/D register.

Behaviour:
- Registers: pc (32), state (RUN/FLUSHED). Async reset: pc=PC_RESET, state=RUN.
- Outputs at reset: F_PC=32'h3000, F_exc_code=0, F_DB=0, null_slot=0, F_instr=im_rdata.
- Next-PC priority at posedge (highest first):
  1. int_exc_req: pc<=PC_KERNEL regardless of en; state<=FLUSHED.
  2. D_eret & en: pc<=epc; state<=FLUSHED.
  3. en & npc_sel & state==RUN: pc<=D_npc.
  4. en: pc<=pc+4, wrapping mod 2^32.
  5. Otherwise hold pc and state.
- FSM:
  - RUN -> FLUSHED on rule 1 or 2.
  - FLUSHED -> RUN on the next cycle with en=1 and no new redirect.
  - FLUSHED with en=0 stays FLUSHED.
  - In FLUSHED, npc_sel and D_is_jump are ignored, because D holds a bubble.
- F_exc_code = 5'd4 if pc[1:0]!=0 or pc<IM_LO or pc>IM_HI; else 0. Combinational from pc.
- F_instr = (F_exc_code!=0) ? 0 : im_rdata.
- F_DB = D_is_jump & (state==RUN) & ~int_exc_req.
- null_slot = D_eret & en & ~int_exc_req.
  - Kills the instruction fetched after eret; eret has no delay slot.
- Simultaneous events:
  - int_exc_req with eret: exception wins; null_slot=0.
  - eret with npc_sel: eret wins.
- Stall (en=0): pc and state hold; outputs stay stable except through im_rdata/inputs.
- Reset asserted mid-operation overrides everything asynchronously.
- A redirect to a bad target (epc or D_npc misaligned) is not pre-checked. The AdEL flag appears when that PC is in F.

Optional Feature:
- Macro FETCH_CNT_EN.
- When defined:
  - Extra output fetch_cnt [31:0], reset 0.
  - Increments by 1 on every posedge where en=1, int_exc_req=0, null_slot=0 and F_exc_code=0.
  - Wraps at 2^32.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then en=1 for 3 cycles, no redirects -> F_PC 3000, 3004, 3008, 300C; F_exc_code=0; F_DB=0.
- At PC=3010: npc_sel=1, D_npc=3400, D_is_jump=1 -> F_DB=1 that cycle; next F_PC=3400; en=0 for 2 cycles holds 3400.
- At PC=3404: int_exc_req=1 with en=0, D_eret=1 -> next F_PC=4180, null_slot=0. Following cycle npc_sel=1, D_npc=3000 is ignored (FLUSHED) -> F_PC=4184.
- D_eret=1, epc=3020, en=1 -> null_slot=1 that cycle; next F_PC=3020, state FLUSHED.
- D_eret=1, epc=3022 -> next F_PC=3022, F_exc_code=4, F_instr=0. Also pc reaching 7000 sequentially -> F_exc_code=4.
- FETCH_CNT_EN: 5 clean fetches, 1 stall, 1 int_exc_req cycle -> fetch_cnt=5. Reset mid-run -> 0 immediately.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   F-stage producer for the F/D pipeline register. It owns the fetch PC,
//   drives the instruction memory address and builds the F bundle
//   {PC, instr, delay-slot flag, exception code}. It also handles the
//   redirects for kernel entry, eret and taken branches/jumps, and raises
//   the null-slot kill that follows an eret.
//
// Optional feature: define FETCH_CNT_EN to add the fetch_cnt output, which
//   counts clean fetches.
//
// Ports
//   clk, reset      posedge clock, asynchronous active-high reset
//   en              F-stage enable (0 = stall)
//   npc_sel, D_npc  taken branch/jump in D and its target
//   D_is_jump       D holds a branch/jump, so the F instr is its delay slot
//   D_eret, epc     eret in D and the forwarded CP0 EPC
//   int_exc_req     CP0 takes an interrupt/exception this cycle
//   im_rdata        IM read data for im_addr
//   im_addr, F_PC   current fetch PC
//   F_instr         fetched instruction, zeroed on an exception
//   F_DB            delay-slot flag
//   F_exc_code      0 or AdEL (4)
//   null_slot       kill request to the F/D register
//   fetch_cnt       clean-fetch counter (FETCH_CNT_EN only)
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] PC_KERNEL = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        npc_sel,
    input  logic [31:0] D_npc,
    input  logic        D_is_jump,
    input  logic        D_eret,
    input  logic [31:0] epc,
    input  logic        int_exc_req,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_DB,
    output logic [4:0]  F_exc_code,
    output logic        null_slot
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    // FLUSHED means D holds a bubble after a redirect, so whatever D says
    // about branches or delay slots is not valid.
    typedef enum logic {RUN, FLUSHED} state_e;

    logic [31:0] pc_q;
    state_e      state_q;
    logic        bad_pc;

    assign bad_pc     = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    assign F_exc_code = bad_pc ? EXC_ADEL : 5'd0;
    assign F_PC       = pc_q;
    assign im_addr    = pc_q;
    assign F_instr    = bad_pc ? 32'd0 : im_rdata;
    assign F_DB       = D_is_jump & (state_q == RUN) & ~int_exc_req;
    // eret has no delay slot: the instruction fetched alongside it is killed.
    assign null_slot  = D_eret & en & ~int_exc_req;

    // Redirect priority: kernel entry, then eret, then taken branch (RUN
    // only), then sequential. Kernel entry ignores the stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            state_q <= RUN;
        end else if (int_exc_req) begin
            pc_q    <= PC_KERNEL;
            state_q <= FLUSHED;
        end else if (en) begin
            if (D_eret) begin
                pc_q    <= epc;
                state_q <= FLUSHED;
            end else if (npc_sel && state_q == RUN) begin
                pc_q    <= D_npc;
                state_q <= RUN;
            end else begin
                pc_q    <= pc_q + 32'd4;
                state_q <= RUN;
            end
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && !int_exc_req && !null_slot && !bad_pc)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign fetch_cnt = cnt_q;
`endif

endmodule
